multi_producer: RTL and testbench

Parametrised successor to the two-channel test producer. It drives `NUM_CH` independent request streams, each carrying an address, an ID and a valid flag, and each honouring its own stall. Flushes are no longer hard-wired: an external flush-request port feeds a small FIFO. The FIFO issues one-cycle flush pulses on the targeted lane, rate-limited by a minimum inter-flush gap. It sits at the head of the global-stall pipeline and feeds the consumer/stall-controller lanes.

---
 rtl/multi_producer_pkg.sv | 15 +
 rtl/multi_producer_flush_fifo.sv | 57 +++++
 rtl/multi_producer.sv | 139 +++++++++++++
 tb/tb_multi_producer.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_producer_pkg.sv
// Shared widths and the flush-entry bundle for multi_producer.
// Address/ID widths plus the flush FIFO entry layout live here.
package multi_producer_pkg;

  localparam int ADDRESS_WIDTH     = 8;
  localparam int ID_WIDTH          = 8;
  localparam int FLUSH_CH_WIDTH    = 4;
  localparam int FLUSH_ENTRY_WIDTH = FLUSH_CH_WIDTH + ID_WIDTH;

  typedef struct packed {
    logic [FLUSH_CH_WIDTH-1:0] ch;
    logic [ID_WIDTH-1:0]       id;
  } flush_entry_t;

endpackage

// File: rtl/multi_producer_flush_fifo.sv
// flush_fifo: synchronous FIFO of flush entries with occupancy count.
// Pushes while full and pops while empty are ignored.
module flush_fifo
  import multi_producer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  flush_entry_t               push_data,
  input  logic                       pop,
  output flush_entry_t               pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  flush_entry_t   mem [DEPTH];
  logic [PW-1:0]  wr_q;
  logic [PW-1:0]  rd_q;
  logic [CW-1:0]  cnt_q;
  logic           full;
  logic           do_push;
  logic           do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PW'(1);
      if (do_pop)  rd_q <= rd_q + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign pop_data = mem[rd_q];
  assign count    = cnt_q;

endmodule

// File: rtl/multi_producer.sv
// multi_producer: NUM_CH request streams plus a rate-limited flush FIFO.
// Define PRODUCER_AUTO_FLUSH_EN for a single self-timed flush entry.
module multi_producer
  import multi_producer_pkg::*;
#(
  parameter int NUM_CH           = 2,
  parameter int ADDR_STRIDE      = 4,
  parameter int TAG_WIDTH        = 4,
  parameter int FLUSH_DEPTH      = 4,
  parameter int FLUSH_GAP        = 4,
  parameter int AUTO_FLUSH_DELAY = 43,
  parameter int AUTO_FLUSH_CH    = 0,
  parameter logic [ID_WIDTH-1:0] AUTO_FLUSH_ID = 8'h16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_CH-1:0]            ch_enable,
  input  logic [NUM_CH-1:0]            in_stall,
  output logic [NUM_CH*ADDRESS_WIDTH-1:0] out_address,
  output logic [NUM_CH*ID_WIDTH-1:0]   out_id,
  output logic [NUM_CH-1:0]            out_valid,
  input  logic                         flush_req_valid,
  output logic                         flush_req_ready,
  input  logic [FLUSH_CH_WIDTH-1:0]    flush_req_ch,
  input  logic [ID_WIDTH-1:0]          flush_req_id,
  output logic [NUM_CH-1:0]            flush,
  output logic [NUM_CH*ID_WIDTH-1:0]   flush_id
);

  localparam int SW  = ID_WIDTH - TAG_WIDTH;
  localparam int CW  = $clog2(FLUSH_DEPTH) + 1;
  localparam int GW  = (FLUSH_GAP > 1) ? $clog2(FLUSH_GAP) : 1;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [ID_WIDTH-1:0]      id_q;
    logic                     valid_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        addr_q  <= '0;
        id_q    <= '0;
        valid_q <= 1'b0;
      end else if (!in_stall[c]) begin
        valid_q <= ch_enable[c];
        if (ch_enable[c]) begin
          addr_q <= addr_q + ADDRESS_WIDTH'(ADDR_STRIDE);
          id_q   <= {TAG_WIDTH'(c + 1), id_q[SW-1:0] + SW'(1)};
        end
      end
    end

    assign out_address[c*ADDRESS_WIDTH +: ADDRESS_WIDTH] = addr_q;
    assign out_id[c*ID_WIDTH +: ID_WIDTH]                = id_q;
    assign out_valid[c]                                  = valid_q;
  end

  flush_entry_t   head;
  flush_entry_t   req_entry;
  flush_entry_t   auto_entry;
  flush_entry_t   push_entry;
  logic [CW-1:0]  fifo_count;
  logic           fifo_empty;
  logic           fifo_full;
  logic           auto_push;
  logic           auto_fire;
  logic           req_push;
  logic           push;
  logic           pop;
  logic [GW-1:0]  gap_q;
  logic [NUM_CH-1:0]          flush_q;
  logic [NUM_CH*ID_WIDTH-1:0] flush_id_q;

  assign fifo_full  = (fifo_count == CW'(FLUSH_DEPTH));
  assign req_entry  = '{ch: flush_req_ch, id: flush_req_id};
  assign auto_entry = '{ch: FLUSH_CH_WIDTH'(AUTO_FLUSH_CH), id: AUTO_FLUSH_ID};

`ifdef PRODUCER_AUTO_FLUSH_EN
  logic [5:0] auto_cnt_q;
  logic       auto_done_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      auto_cnt_q  <= 6'(AUTO_FLUSH_DELAY);
      auto_done_q <= 1'b0;
    end else begin
      if (auto_cnt_q != '0) auto_cnt_q <= auto_cnt_q - 6'd1;
      if (auto_fire)        auto_done_q <= 1'b1;
    end
  end

  // Pending until a slot frees, then fires exactly once.
  assign auto_push = (auto_cnt_q == '0) && !auto_done_q;
`else
  assign auto_push = (AUTO_FLUSH_DELAY < 0);
`endif

  assign auto_fire       = auto_push && !fifo_full;
  assign flush_req_ready = !fifo_full && !auto_push;
  // Out-of-range channels complete the handshake but never enqueue.
  assign req_push   = flush_req_valid && flush_req_ready &&
                      (flush_req_ch < FLUSH_CH_WIDTH'(NUM_CH));
  assign push       = auto_fire || req_push;
  assign push_entry = auto_fire ? auto_entry : req_entry;
  assign pop        = !fifo_empty && (gap_q == '0);

  flush_fifo #(
    .DEPTH (FLUSH_DEPTH)
  ) u_flush_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gap_q      <= '0;
      flush_q    <= '0;
      flush_id_q <= '0;
    end else begin
      if (pop)                gap_q <= GW'(FLUSH_GAP - 1);
      else if (gap_q != '0)   gap_q <= gap_q - GW'(1);
      for (int c = 0; c < NUM_CH; c++) begin
        flush_q[c] <= pop && (head.ch == FLUSH_CH_WIDTH'(c));
        flush_id_q[c*ID_WIDTH +: ID_WIDTH] <=
          (pop && (head.ch == FLUSH_CH_WIDTH'(c))) ? head.id : '0;
      end
    end
  end

  assign flush    = flush_q;
  assign flush_id = flush_id_q;

endmodule

// File: tb/tb_multi_producer.sv
// Directed bench for multi_producer: streams, stall, enable, flush FIFO.
// Auto-flush expectations follow PRODUCER_AUTO_FLUSH_EN when defined.
module tb_multi_producer;

  localparam int NCH = 2;
  localparam int AW  = 8;
  localparam int IW  = 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NCH-1:0]    ch_enable = '1;
  logic [NCH-1:0]    in_stall = '0;
  logic [NCH*AW-1:0] out_address;
  logic [NCH*IW-1:0] out_id;
  logic [NCH-1:0]    out_valid;
  logic              flush_req_valid = 1'b0;
  logic              flush_req_ready;
  logic [3:0]        flush_req_ch = '0;
  logic [IW-1:0]     flush_req_id = '0;
  logic [NCH-1:0]    flush;
  logic [NCH*IW-1:0] flush_id;

  int errors = 0;
  int checks = 0;

  logic [3:0] ech [6]   = '{4'd0, 4'd1, 4'd1, 4'd0, 4'd1, 4'd0};
  logic [7:0] eid [6]   = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
  int         pedge [6] = '{2, 6, 10, 14, 18, 22};

  always #5 clk = ~clk;

  multi_producer #(
    .NUM_CH      (NCH),
    .ADDR_STRIDE (4),
    .TAG_WIDTH   (4),
    .FLUSH_DEPTH (4),
    .FLUSH_GAP   (4)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .ch_enable       (ch_enable),
    .in_stall        (in_stall),
    .out_address     (out_address),
    .out_id          (out_id),
    .out_valid       (out_valid),
    .flush_req_valid (flush_req_valid),
    .flush_req_ready (flush_req_ready),
    .flush_req_ch    (flush_req_ch),
    .flush_req_id    (flush_req_id),
    .flush           (flush),
    .flush_id        (flush_id)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n         = 1'b0;
    flush_req_valid = 1'b0;
    ch_enable       = '1;
    in_stall        = '0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) tick();
    checks++;
    if ({out_address, out_id, out_valid, flush, flush_id} !== '0)
      $display("FAIL reset_outputs got %h want 0",
               {out_address, out_id, out_valid, flush, flush_id});
    if ({out_address, out_id, out_valid, flush, flush_id} !== '0) errors++;
    checks++;
    if (flush_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b want 1", flush_req_ready);
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if ({out_address, out_id, out_valid} !== {16'h0404, 16'h2111, 2'b11}) begin
      errors++;
      $display("FAIL first_advance got %h want %h",
               {out_address, out_id, out_valid}, {16'h0404, 16'h2111, 2'b11});
    end
    repeat (14) tick();
    checks++;
    if (out_id[7:0] !== 8'h1F) begin
      errors++;
      $display("FAIL seq_15 got %h want 1f", out_id[7:0]);
    end
    tick();
    checks++;
    if ({out_address[7:0], out_id[7:0]} !== {8'h40, 8'h10}) begin
      errors++;
      $display("FAIL seq_wrap got %h want 4010",
               {out_address[7:0], out_id[7:0]});
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({out_address, out_id, out_valid, flush, flush_id} !== '0) begin
      errors++;
      $display("FAIL async_reset got %h want 0",
               {out_address, out_id, out_valid});
    end
  endtask

  task automatic test_stall();
    do_reset();
    repeat (2) tick();
    in_stall = 2'b01;
    repeat (3) tick();
    checks++;
    if ({out_address[7:0], out_id[7:0], out_valid[0]} !== {8'd8, 8'h12, 1'b1}) begin
      errors++;
      $display("FAIL stall_hold got %h want %h",
               {out_address[7:0], out_id[7:0], out_valid[0]}, {8'd8, 8'h12, 1'b1});
    end
    checks++;
    if ({out_address[15:8], out_id[15:8]} !== {8'd20, 8'h25}) begin
      errors++;
      $display("FAIL stall_other got %h want 1425",
               {out_address[15:8], out_id[15:8]});
    end
    in_stall = 2'b00;
    tick();
    checks++;
    if ({out_address, out_id} !== {8'd24, 8'd12, 8'h26, 8'h13}) begin
      errors++;
      $display("FAIL stall_resume got %h want %h",
               {out_address, out_id}, {8'd24, 8'd12, 8'h26, 8'h13});
    end
    repeat (57) tick();
    checks++;
    if ({out_address[15:8], out_id[15:8]} !== {8'hFC, 8'h2F}) begin
      errors++;
      $display("FAIL addr_pre_wrap got %h want fc2f",
               {out_address[15:8], out_id[15:8]});
    end
    tick();
    checks++;
    if ({out_address[15:8], out_id[15:8]} !== {8'h00, 8'h20}) begin
      errors++;
      $display("FAIL addr_wrap got %h want 0020",
               {out_address[15:8], out_id[15:8]});
    end
  endtask

  task automatic test_enable();
    do_reset();
    repeat (2) tick();
    ch_enable = 2'b01;
    tick();
    checks++;
    if ({out_address[15:8], out_id[15:8], out_valid[1]} !== {8'd8, 8'h22, 1'b0}) begin
      errors++;
      $display("FAIL disable_first got %h want %h",
               {out_address[15:8], out_id[15:8], out_valid[1]}, {8'd8, 8'h22, 1'b0});
    end
    repeat (2) tick();
    checks++;
    if ({out_address[15:8], out_id[15:8], out_valid[1]} !== {8'd8, 8'h22, 1'b0}) begin
      errors++;
      $display("FAIL disable_freeze got %h want %h",
               {out_address[15:8], out_id[15:8], out_valid[1]}, {8'd8, 8'h22, 1'b0});
    end
    checks++;
    if ({out_address[7:0], out_id[7:0], out_valid[0]} !== {8'd20, 8'h15, 1'b1}) begin
      errors++;
      $display("FAIL disable_other got %h want %h",
               {out_address[7:0], out_id[7:0], out_valid[0]}, {8'd20, 8'h15, 1'b1});
    end
    ch_enable = 2'b11;
    tick();
    checks++;
    if ({out_address[15:8], out_id[15:8], out_valid[1]} !== {8'd12, 8'h23, 1'b1}) begin
      errors++;
      $display("FAIL reenable got %h want %h",
               {out_address[15:8], out_id[15:8], out_valid[1]}, {8'd12, 8'h23, 1'b1});
    end
  endtask

  task automatic test_single_flush();
    logic seen;
    do_reset();
    flush_req_ch    = 4'd1;
    flush_req_id    = 8'h25;
    flush_req_valid = 1'b1;
    checks++;
    if (flush_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_ready got %b want 1", flush_req_ready);
    end
    tick();
    flush_req_valid = 1'b0;
    checks++;
    if ({flush, flush_id} !== '0) begin
      errors++;
      $display("FAIL flush_early got %h want 0", {flush, flush_id});
    end
    tick();
    checks++;
    if ({flush, flush_id} !== {2'b10, 16'h2500}) begin
      errors++;
      $display("FAIL flush_pulse got %h want %h", {flush, flush_id}, {2'b10, 16'h2500});
    end
    tick();
    checks++;
    if ({flush, flush_id} !== '0) begin
      errors++;
      $display("FAIL flush_one_cycle got %h want 0", {flush, flush_id});
    end
    repeat (4) tick();
    flush_req_ch    = 4'd7;
    flush_req_id    = 8'h77;
    flush_req_valid = 1'b1;
    checks++;
    if (flush_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bad_ch_ready got %b want 1", flush_req_ready);
    end
    tick();
    flush_req_ch = 4'd0;
    flush_req_id = 8'h5A;
    tick();
    flush_req_valid = 1'b0;
    checks++;
    if ({flush, flush_id} !== '0) begin
      errors++;
      $display("FAIL bad_ch_pulse got %h want 0", {flush, flush_id});
    end
    tick();
    checks++;
    if ({flush, flush_id} !== {2'b01, 16'h005A}) begin
      errors++;
      $display("FAIL after_bad_ch got %h want %h", {flush, flush_id}, {2'b01, 16'h005A});
    end
    seen = 1'b0;
    repeat (6) begin
      tick();
      seen = seen | (|flush);
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL stray_pulse got %b want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    int sent;
    logic acc;
    logic exp_rdy;
    logic [NCH-1:0] exp_f;
    logic [NCH*IW-1:0] exp_fid;
    do_reset();
    sent = 0;
    for (int e = 1; e <= 26; e++) begin
      flush_req_valid = (sent < 6);
      flush_req_ch    = (sent < 6) ? ech[sent] : 4'd0;
      flush_req_id    = (sent < 6) ? eid[sent] : 8'h00;
      if (e <= 12) begin
        exp_rdy = !(e == 6 || (e >= 8 && e <= 10));
        checks++;
        if (flush_req_ready !== exp_rdy) begin
          errors++;
          $display("FAIL bp_ready edge %0d got %b want %b", e, flush_req_ready, exp_rdy);
        end
      end
      acc = flush_req_valid && flush_req_ready;
      tick();
      if (acc) sent++;
      exp_f   = '0;
      exp_fid = '0;
      for (int k = 0; k < 6; k++) begin
        if (pedge[k] == e) begin
          exp_f[ech[k]] = 1'b1;
          exp_fid[ech[k]*IW +: IW] = eid[k];
        end
      end
      checks++;
      if ({flush, flush_id} !== {exp_f, exp_fid}) begin
        errors++;
        $display("FAIL bp_pulse edge %0d got %h want %h", e, {flush, flush_id}, {exp_f, exp_fid});
      end
    end
    flush_req_valid = 1'b0;
    checks++;
    if (sent !== 6) begin
      errors++;
      $display("FAIL bp_accepted got %0d want 6", sent);
    end
  endtask

  task automatic test_auto_flush();
    logic exp_rdy;
    logic [NCH-1:0] exp_f;
    logic [NCH*IW-1:0] exp_fid;
    do_reset();
    for (int e = 1; e <= 60; e++) begin
`ifdef PRODUCER_AUTO_FLUSH_EN
      exp_rdy = (e != 44);
`else
      exp_rdy = 1'b1;
`endif
      checks++;
      if (flush_req_ready !== exp_rdy) begin
        errors++;
        $display("FAIL auto_ready edge %0d got %b want %b", e, flush_req_ready, exp_rdy);
      end
      tick();
      exp_f   = '0;
      exp_fid = '0;
`ifdef PRODUCER_AUTO_FLUSH_EN
      if (e == 45) begin
        exp_f   = 2'b01;
        exp_fid = 16'h0016;
      end
`endif
      checks++;
      if ({flush, flush_id} !== {exp_f, exp_fid}) begin
        errors++;
        $display("FAIL auto_pulse edge %0d got %h want %h", e, {flush, flush_id}, {exp_f, exp_fid});
      end
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_enable();
    test_single_flush();
    test_back_to_back();
    test_auto_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
